// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Result is computed at accept and released to HI/LO after a fixed latency.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        MDStall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_tmp, lo_tmp;
  logic          wr_tmp;
  logic          accept, mt_hi, mt_lo, done;

  logic [63:0]        prod_s, prod_u;
  logic               ovf, dz;
  logic [31:0]        dvs;
  logic signed [31:0] a_s, d_s;
  logic [31:0]        quo_s, rem_s, quo_u, rem_u;
  logic [31:0]        res_hi, res_lo;
  logic               res_wr;

  assign Busy    = (state_q == BUSY);
  assign MDStall = Busy | (Start & (MDOp <= 3'd3));

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divisor is forced to 1 for the zero and overflow cases so the
  // divider never sees an undefined operand pair.
  assign dz  = (B == 32'd0);
  assign ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign dvs = (dz || ovf) ? 32'd1 : B;
  assign a_s = $signed(A);
  assign d_s = $signed(dvs);

  assign quo_s = ovf ? 32'h8000_0000 : 32'(a_s / d_s);
  assign rem_s = ovf ? 32'd0 : 32'(a_s % d_s);
  assign quo_u = A / dvs;
  assign rem_u = A % dvs;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b1;
    unique case (MDOp[1:0])
      2'd0: {res_hi, res_lo} = prod_s;
      2'd1: {res_hi, res_lo} = prod_u;
      2'd2: begin
        res_hi = rem_s;
        res_lo = quo_s;
        res_wr = !dz;
      end
      default: begin
        res_hi = rem_u;
        res_lo = quo_u;
        res_wr = !dz;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          unique case (1'b1)
            (MDOp <= 3'd3): begin
              accept  = 1'b1;
              state_d = BUSY;
            end
            (MDOp == 3'd4): mt_hi = 1'b1;
            (MDOp == 3'd5): mt_lo = 1'b1;
            default: ;
          endcase
        end
      end
      default: begin
        if (cnt_q == CW'(1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_tmp  <= '0;
      lo_tmp  <= '0;
      wr_tmp  <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hi_tmp <= res_hi;
        lo_tmp <= res_lo;
        wr_tmp <= res_wr;
        cnt_q  <= MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (done && wr_tmp) begin
        HI <= hi_tmp;
        LO <= lo_tmp;
      end
      if (mt_hi) HI <= A;
      if (mt_lo) LO <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO/latency queued at issue,
// checked by a monitor when Busy falls.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy, MDStall;
  logic [31:0] HI, LO;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .MDStall(MDStall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   bcnt  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      bcnt = 0;
    end else if (Busy) begin
      bcnt++;
    end else if (bcnt != 0) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got HI=%h LO=%h expected none", HI, LO);
      end else begin
        e = q.pop_front();
        chk("sb_hi", HI, e.hi);
        chk("sb_lo", LO, e.lo);
        chk("sb_busy_cycles", 32'(bcnt), 32'(e.cyc));
      end
      bcnt = 0;
    end
  end

  task automatic op(input logic [2:0] o, input logic [31:0] a,
                    input logic [31:0] b);
    Start = 1'b1;
    MDOp  = o;
    A     = a;
    B     = b;
    @(posedge clk); #1;
    Start = 1'b0;
    A     = 32'h5A5A_1234;
    B     = 32'h0F0F_9999;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40 && Busy; k++) begin
      @(posedge clk); #1;
    end
    if (Busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: got Busy=1 expected 0 within 40 cycles");
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l,
                      input int c);
    exp_t e;
    e.hi  = h;
    e.lo  = l;
    e.cyc = c;
    q.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset during the third busy cycle of a MULT
    op(3'd0, 32'd3, 32'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", 32'(Busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", 32'(Busy), 32'h0);
    chk("async_hi", HI, 32'h0);
    chk("async_lo", LO, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_hi", HI, 32'h0);
    chk("post_rst_lo", LO, 32'h0);

    push(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    op(3'd0, 32'hFFFF_FFFF, 32'h2);
    wait_idle();
    push(32'h0000_0001, 32'hFFFF_FFFE, 5);
    op(3'd1, 32'hFFFF_FFFF, 32'h2);
    wait_idle();
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    op(3'd2, 32'hFFFF_FFF9, 32'h2);
    wait_idle();
    push(32'h1, 32'h3, 10);
    op(3'd3, 32'd7, 32'd2);
    wait_idle();
    @(posedge clk); #1;

    // Back-to-back MTHI / MTLO
    Start = 1'b1; MDOp = 3'd4; A = 32'h1234_5678;
    #1 chk("mthi_stall", 32'(MDStall), 32'h0);
    @(posedge clk); #1;
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_busy", 32'(Busy), 32'h0);
    MDOp = 3'd5; A = 32'h9ABC_DEF0;
    #1 chk("mtlo_stall", 32'(MDStall), 32'h0);
    @(posedge clk); #1;
    chk("mtlo_lo", LO, 32'h9ABC_DEF0);
    chk("mtlo_hi_kept", HI, 32'h1234_5678);
    chk("mtlo_busy", 32'(Busy), 32'h0);
    Start = 1'b0;
    #1 chk("idle_stall", 32'(MDStall), 32'h0);

    // Reserved opcode leaves everything alone
    op(3'd6, 32'hFFFF_0000, 32'h1);
    chk("rsv_busy", 32'(Busy), 32'h0);
    chk("rsv_hi", HI, 32'h1234_5678);
    chk("rsv_lo", LO, 32'h9ABC_DEF0);

    // Divide by zero keeps preloaded values
    op(3'd4, 32'hAAAA_0000, 32'h0);
    op(3'd5, 32'h0000_BBBB, 32'h0);
    push(32'hAAAA_0000, 32'h0000_BBBB, 10);
    Start = 1'b1; MDOp = 3'd3; A = 32'd55; B = 32'd0;
    #1 chk("md_stall", 32'(MDStall), 32'h1);
    @(posedge clk); #1;
    Start = 1'b0;
    wait_idle();
    push(32'h0, 32'h8000_0000, 10);
    op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();

    // MTLO during busy cycle 2 must be ignored
    push(32'h1, 32'h0, 5);
    op(3'd0, 32'h0001_0000, 32'h0001_0000);
    @(posedge clk); #1;
    Start = 1'b1; MDOp = 3'd5; A = 32'hDEAD_BEEF;
    #1 chk("busy_stall", 32'(MDStall), 32'h1);
    @(posedge clk); #1;
    Start = 1'b0;
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
